fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write-port arbiter that lets up to N producers share the single write port of `synchronous_FIFO`. Each cycle it selects at most one requesting producer, steers that producer's byte onto the FIFO write port, and acknowledges it with a one-hot grant. A producer can hold ownership for a bounded burst of consecutive writes. The arbiter honours the FIFO `full` flag so that no write is ever issued into a full FIFO.

## Interface
- `N`, 4: number of producers, 2..8.
- `DW`, 8: data width; matches FIFO `datain` width.
- `MAX_BURST`, 4: maximum consecutive writes per ownership, 1..15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; 0 = in reset.
- `req`  in  N  per-producer write request; bit i is producer i.
- `wdata`  in  N*DW  packed producer data; producer i occupies bits [i*DW +: DW].
- `full`  in  1  FIFO full flag.
- `gnt`  out  N  one-hot grant. `gnt[i]`=1 means producer i's data is written at this rising edge.
- `Write_En`  out  1  to FIFO `Write_En`; equals OR of `gnt`.
- `fifo_datain`  out  DW  to FIFO `datain`; data of the granted producer, otherwise 0.
- `busy`  out  1  1 while in BURST state, i.e. a producer holds ownership.
- `owner`  out  clog2(N)  index of the current or last granted producer.

## Operation
- Registered state:
  - `ptr`: round-robin start index.
  - `st`: IDLE or BURST.
  - `own`: owning producer index.
  - `cnt`: 4-bit burst count.
  - All four reset to 0 / IDLE.
- `gnt`, `Write_En` and `fifo_datain` are combinational from the registered state, `req` and `full`. A producer samples `gnt[i]` before the edge; its data is consumed at that edge.
- **Arbitration (IDLE):**
  - Pick the first i with `req[i]`=1, searching circularly from `ptr`: ptr, ptr+1, …, N-1, 0, ….
  - If such an i exists and `full`=0, grant i and set `cnt`=1.
  - If `MAX_BURST`=1: `ptr`←(i+1) mod N and stay in IDLE.
  - Otherwise: `own`←i and move to BURST.
- **BURST:**
  - `req[own]`=1 and `full`=0: grant `own` and increment `cnt`.
    - If the incremented `cnt` equals `MAX_BURST`: go to IDLE with `ptr`←(own+1) mod N.
  - `req[own]`=0: ownership is released in the same cycle, with no bubble cycle.
    - Arbitrate as in IDLE, but search from (own+1) mod N.
    - If someone is granted, the IDLE rules apply to the new winner.
    - If nobody is granted, go to IDLE with `ptr`←(own+1) mod N.
- **`full`=1 (any state):**
  - `gnt`=0 and `Write_En`=0.
  - `st`, `own`, `cnt` and `ptr` hold.
  - A stalled cycle does not consume burst count.
  - When `full`=1 and `req[own]`=0 occur together in BURST, release still happens (state goes to IDLE with `ptr`←(own+1) mod N), but nothing is granted.
- At most one `gnt` bit is ever set. `gnt[i]` is never set while `req[i]`=0.
- `owner` updates to the granted index and holds otherwise. `busy` = (`st`==BURST).
- Width rule: `cnt` compares against `MAX_BURST` as a 4-bit value, and `MAX_BURST` never exceeds 15.

## Timing
- While `reset`=0:
  - `gnt`=0, `Write_En`=0, `fifo_datain`=0, `busy`=0, `owner`=0.
  - Forced asynchronously, independent of `req`.
- Reset asserted mid-burst: state clears immediately. After release, arbitration restarts from producer 0.
- Latency: a request that wins is granted in the same cycle it is presented, with zero-cycle request-to-write.
- `full` reacts combinationally. Because the FIFO flag is registered, the arbiter never issues a write on the edge where the FIFO holds 8 entries.
- Worst-case wait for a continuously requesting producer: (N-1)·MAX_BURST granted cycles plus any `full` stall cycles.

## Test plan
1. **Reset:** hold `reset`=0 with `req`=4'b1111.
   - Expect `gnt`=0, `Write_En`=0 and `fifo_datain`=0 throughout.
   - After release, the first grant is `gnt`=4'b0001.
2. **Full contention:** `req`=4'b1111, `MAX_BURST`=4, producer i drives data 8'h10·i+k, FIFO drained continuously.
   - Grants: 4× producer 0, 4× producer 1, 4× producer 2, 4× producer 3, then back to producer 0.
   - The FIFO reads back 8'h00..03, 8'h10..13, 8'h20..23, 8'h30..33.
3. **Early release:** producer 1 requests for 2 cycles then drops, producer 3 requests constantly.
   - Grant sequence: 1, 1, then 3 on the very next cycle with no bubble.
   - `busy` stays 1 and `owner` changes 1→3.
4. **Full backpressure:** producer 0 alone writes 8'h00..8'h0A, with no reads.
   - Exactly 8 writes occur, then `Write_En`=0 while `full`=1.
   - After one read, the next write resumes.
   - Burst count is not consumed during the stall.
5. **Single-beat mode:** `MAX_BURST`=1, `req`=4'b0101.
   - Grants alternate 0, 2, 0, 2; `busy` is never 1.
6. **Reset mid-burst:** assert `reset` during producer 2's second beat.
   - Outputs clear immediately.
   - After release with `req`=4'b0100, producer 2 gets a fresh burst of 4 grants.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_arbiter
// Purpose  : Round-robin, burst-capable arbiter sharing one FIFO write port
//            among N producers; never writes while the FIFO reports full.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*DW-1:0]      wdata,
    input  logic                 full,
    output logic [N-1:0]         gnt,
    output logic                 Write_En,
    output logic [DW-1:0]        fifo_datain,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner
);

    localparam int IW = $clog2(N);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t        st_q, st_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] own_q, own_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [3:0]    cnt_q, cnt_d;

    logic [IW-1:0] w_base;
    logic [IW-1:0] w_cand;
    logic [IW-1:0] w_pick;
    logic          w_found;
    logic          w_gnt_vld;
    logic [IW-1:0] w_gnt_idx;
    logic [N-1:0]  w_gnt;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        if (v == IW'(N - 1)) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    // A released owner hands the search start to its successor, so the
    // hand-over happens in the same cycle without a bubble.
    always_comb begin
        if (st_q == S_BURST && !req[own_q]) begin
            w_base = wrap_inc(own_q);
        end else begin
            w_base = ptr_q;
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = w_base;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
            w_cand = wrap_inc(w_cand);
        end
    end

    always_comb begin
        st_d      = st_q;
        ptr_d     = ptr_q;
        own_d     = own_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;

        if (st_q == S_BURST && req[own_q]) begin
            if (!full) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = own_q;
                owner_d   = own_q;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q + 4'd1 == 4'(MAX_BURST)) begin
                    st_d  = S_IDLE;
                    ptr_d = wrap_inc(own_q);
                end
            end
        end else if (w_found && !full) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_pick;
            owner_d   = w_pick;
            cnt_d     = 4'd1;
            if (MAX_BURST == 1) begin
                st_d  = S_IDLE;
                ptr_d = wrap_inc(w_pick);
            end else begin
                st_d  = S_BURST;
                own_d = w_pick;
            end
        end else if (st_q == S_BURST) begin
            // Owner dropped its request with no successor (or FIFO full).
            st_d  = S_IDLE;
            ptr_d = wrap_inc(own_q);
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_gnt[i] = reset && w_gnt_vld && (w_gnt_idx == IW'(i));
        end
    end

    always_comb begin
        fifo_datain = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                fifo_datain = fifo_datain | wdata[i*DW +: DW];
            end
        end
    end

    assign gnt      = w_gnt;
    assign Write_En = |w_gnt;
    assign busy     = (st_q == S_BURST);
    assign owner    = owner_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q    <= S_IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
            owner_q <= '0;
        end else begin
            st_q    <= st_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write_arbiter
// Purpose  : Directed and randomized checks of fifo_write_arbiter against a
//            behavioural arbitration model and an 8-deep FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req   = '0;
    logic [N-1:0]    req1  = '0;
    logic [N*DW-1:0] wdata = '0;
    logic            full  = 1'b0;
    logic            full1 = 1'b0;

    logic [N-1:0]    gnt, gnt1;
    logic            we, we1;
    logic [DW-1:0]   dout, dout1;
    logic            busy, busy1;
    logic [1:0]      owner, owner1;

    fifo_write_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB)) u_dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .full(full),
        .gnt(gnt), .Write_En(we), .fifo_datain(dout), .busy(busy), .owner(owner)
    );

    fifo_write_arbiter #(.N(N), .DW(DW), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .wdata(wdata), .full(full1),
        .gnt(gnt1), .Write_En(we1), .fifo_datain(dout1), .busy(busy1), .owner(owner1)
    );

    always #5 clk = ~clk;

    // Behavioural model: which producer owns the port, how many beats it has
    // used, and where the next circular search begins.
    int   m_busy, m_own, m_cnt, m_ptr, m_owner;
    int   e_idx;
    logic [DW-1:0] e_dat;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] pops[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_own = 0; m_cnt = 0; m_ptr = 0; m_owner = 0;
    endtask

    function automatic int pick();
        int base;
        if (!reset) return -1;
        if (m_busy != 0 && req[m_own]) return full ? -1 : m_own;
        base = (m_busy != 0) ? (m_own + 1) % N : m_ptr;
        for (int k = 0; k < N; k++) begin
            if (req[(base + k) % N]) return full ? -1 : (base + k) % N;
        end
        return -1;
    endfunction

    task automatic settle_check();
        #1;
        e_idx = pick();
        e_dat = (e_idx >= 0) ? wdata[e_idx*DW +: DW] : '0;
        chk("gnt",   gnt,  (e_idx >= 0) ? (1 << e_idx) : 0);
        chk("wen",   we,   (e_idx >= 0) ? 1 : 0);
        chk("data",  dout, e_dat);
        chk("busy",  busy, m_busy);
        chk("owner", owner, m_owner);
    endtask

    task automatic edge_commit(input bit rd);
        @(posedge clk);
        #1;
        if (!reset) begin
            model_reset();
        end else if (m_busy != 0 && req[m_own]) begin
            if (e_idx >= 0) begin
                m_cnt++;
                m_owner = m_own;
                if (m_cnt == MB) begin
                    m_busy = 0;
                    m_ptr  = (m_own + 1) % N;
                end
            end
        end else if (e_idx >= 0) begin
            m_owner = e_idx;
            m_cnt   = 1;
            m_busy  = 1;
            m_own   = e_idx;
        end else if (m_busy != 0) begin
            m_busy = 0;
            m_ptr  = (m_own + 1) % N;
        end
        if (rd && fifo_q.size() > 0) pops.push_back(fifo_q.pop_front());
        if (e_idx >= 0) fifo_q.push_back(e_dat);
        full = (fifo_q.size() >= 8);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        req1  = '0;
        model_reset();
        repeat (2) begin
            settle_check();
            edge_commit(1'b0);
        end
        fifo_q.delete();
        pops.delete();
        full  = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kcnt[N];
        int nwr;

        // Reset held with every producer requesting: outputs stay quiet.
        model_reset();
        req = 4'b1111;
        repeat (3) begin
            settle_check();
            edge_commit(1'b0);
        end
        reset = 1'b1;

        // Full contention with continuous draining.
        for (int i = 0; i < N; i++) kcnt[i] = 0;
        for (int c = 0; c < 18; c++) begin
            for (int i = 0; i < N; i++) wdata[i*DW +: DW] = 8'(16 * i + kcnt[i]);
            settle_check();
            chk("t2_rr_gnt", gnt, 1 << ((c / 4) % 4));
            edge_commit(1'b1);
            if (e_idx >= 0) kcnt[e_idx]++;
        end
        for (int j = 0; j < 16; j++) begin
            chk("t2_readback", (j < pops.size()) ? pops[j] : 8'hxx, 16 * (j / 4) + (j % 4));
        end

        // Early release hands over without a bubble.
        do_reset();
        req = 4'b1010 & 4'b0010 | 4'b1000;
        req = 4'b0010 | 4'b1000;
        repeat (2) begin
            settle_check();
            chk("t3_gnt1", gnt, 4'b0010);
            edge_commit(1'b1);
        end
        req = 4'b1000;
        settle_check();
        chk("t3_gnt3", gnt, 4'b1000);
        chk("t3_busy_ho", busy, 1);
        edge_commit(1'b1);
        settle_check();
        chk("t3_busy", busy, 1);
        chk("t3_owner", owner, 3);
        edge_commit(1'b1);

        // Backpressure: no reads, eight writes then stall.
        do_reset();
        req = 4'b0001;
        nwr = 0;
        for (int c = 0; c < 11; c++) begin
            wdata[DW-1:0] = 8'(nwr);
            settle_check();
            if (full) chk("t4_stall_wen", we, 0);
            if (we) nwr++;
            edge_commit(1'b0);
        end
        chk("t4_nwrites", nwr, 8);
        chk("t4_full", full, 1);
        settle_check();
        edge_commit(1'b1);
        wdata[DW-1:0] = 8'(nwr);
        settle_check();
        chk("t4_resume_wen", we, 1);
        chk("t4_resume_data", dout, 8'h08);
        edge_commit(1'b0);

        // Single-beat instance alternates and never enters a burst.
        do_reset();
        req1 = 4'b0101;
        for (int c = 0; c < 4; c++) begin
            settle_check();
            chk("t5_gnt", gnt1, (c % 2 == 0) ? 4'b0001 : 4'b0100);
            chk("t5_wen", we1, 1);
            chk("t5_busy", busy1, 0);
            edge_commit(1'b1);
        end
        req1 = '0;

        // Reset during producer 2's second beat, then a fresh full burst.
        do_reset();
        req = 4'b0100;
        settle_check();
        chk("t6_beat1", gnt, 4'b0100);
        edge_commit(1'b1);
        settle_check();
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_wen", we, 0);
        chk("t6_rst_data", dout, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_owner", owner, 0);
        @(posedge clk);
        #1;
        fifo_q.delete();
        full  = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle_check();
            chk("t6_fresh_gnt", gnt, 4'b0100);
            edge_commit(1'b1);
        end
        settle_check();
        chk("t6_burst_done", busy, 0);
        edge_commit(1'b1);

        // Randomized traffic with random draining.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req   = 4'($urandom);
            wdata = 32'($urandom);
            settle_check();
            edge_commit($urandom_range(0, 9) < 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
